// File: rtl/pflink_crc_pkg.sv
// Shared widths, CRC constants and lock-state encoding for the pflink receive-side checker.
package pflink_crc_pkg;

   localparam int PAYLOAD_W = 13;
   localparam int CRC_W     = 8;
   localparam int WORD_W    = PAYLOAD_W + CRC_W;

   localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
   localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_e;

   // One serial step of the MSB-first CRC-8 shift register.
   function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                  input logic din);
      logic fb;
      fb = crc[CRC_W-1] ^ din;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_INIT);
   endfunction

endpackage

// File: rtl/pflink_crc8_calc13.sv
// Combinational CRC-8 (x^8+x^2+x+1, init 0) over a 13-bit payload, payload[12] shifted in first.
module pflink_crc8_calc13
   import pflink_crc_pkg::*;
(
   input  logic [PAYLOAD_W-1:0] data_i,
   output logic [CRC_W-1:0]     crc_o
);

   always_comb begin
      crc_o = CRC_INIT;
      for (int i = PAYLOAD_W-1; i >= 0; i--) begin
         crc_o = crc8_step(crc_o, data_i[i]);
      end
   end

endmodule

// File: rtl/pflink_crc_checker.sv
// pflink receive CRC checker: one-deep valid/ready output register, lock FSM, statistics.
// Statistics counters are built only when PFLINK_CRC_STATS_EN is defined.
//
// state     | meaning
// ST_HUNT   | searching for LOCK_CNT consecutive good words
// ST_LOCKED | link locked, UNLOCK_CNT consecutive bad words drop lock
module pflink_crc_checker
   import pflink_crc_pkg::*;
#(
   parameter int unsigned LOCK_CNT   = 8,
   parameter int unsigned UNLOCK_CNT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic                 out_crc_ok,
   output logic                 locked,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [CNT_W-1:0]     word_cnt
);

   localparam logic [7:0] LOCK_TC   = 8'(LOCK_CNT);
   localparam logic [7:0] UNLOCK_TC = 8'(UNLOCK_CNT);

   logic [PAYLOAD_W-1:0] payload;
   logic [CRC_W-1:0]     crc_calc;
   logic                 crc_ok;
   logic                 accept;

   lock_state_e          state_q, state_d;
   logic [7:0]           good_run_q, good_run_d;
   logic [7:0]           bad_run_q, bad_run_d;
   logic                 out_valid_q;
   logic [PAYLOAD_W-1:0] out_data_q;
   logic                 out_crc_ok_q;

   assign payload = in_data[WORD_W-1:CRC_W];

   pflink_crc8_calc13 u_crc (
      .data_i (payload),
      .crc_o  (crc_calc)
   );

   assign crc_ok   = (crc_calc == in_data[CRC_W-1:0]);
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_crc_ok_q <= 1'b0;
      end else if (accept) begin
         out_valid_q  <= 1'b1;
         out_data_q   <= payload;
         out_crc_ok_q <= crc_ok;
      end else if (out_ready) begin
         out_valid_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_HUNT;
         good_run_q <= '0;
         bad_run_q  <= '0;
      end else begin
         state_q    <= state_d;
         good_run_q <= good_run_d;
         bad_run_q  <= bad_run_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      good_run_d = good_run_q;
      bad_run_d  = bad_run_q;
      if (accept) begin
         unique case (state_q)
            ST_HUNT: begin
               if (!crc_ok) begin
                  good_run_d = '0;
               end else if (good_run_q + 8'd1 == LOCK_TC) begin
                  state_d    = ST_LOCKED;
                  good_run_d = '0;
                  bad_run_d  = '0;
               end else begin
                  good_run_d = good_run_q + 8'd1;
               end
            end
            ST_LOCKED: begin
               if (crc_ok) begin
                  bad_run_d = '0;
               end else if (bad_run_q + 8'd1 == UNLOCK_TC) begin
                  state_d    = ST_HUNT;
                  good_run_d = '0;
                  bad_run_d  = '0;
               end else begin
                  bad_run_d = bad_run_q + 8'd1;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_crc_ok = out_crc_ok_q;
   assign locked     = (state_q == ST_LOCKED);

`ifdef PFLINK_CRC_STATS_EN
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] word_cnt_q;

   // Clear has priority so a word accepted in the clear cycle is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q  <= '0;
         word_cnt_q <= '0;
      end else if (cnt_clr) begin
         err_cnt_q  <= '0;
         word_cnt_q <= '0;
      end else if (accept) begin
         if (!(&word_cnt_q)) word_cnt_q <= word_cnt_q + 1'b1;
         if (!crc_ok && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign err_cnt  = err_cnt_q;
   assign word_cnt = word_cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign err_cnt        = '0;
   assign word_cnt       = '0;
`endif

endmodule

// File: tb/tb_pflink_crc_checker.sv
// Self-checking bench for pflink_crc_checker: vector table, directed corner sequences, random traffic vs model.
module tb_pflink_crc_checker;

`ifdef PFLINK_CRC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int LOCK_N   = 8;
   localparam int UNLOCK_N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        cnt_clr = 1'b0;
   logic [20:0] in_data = '0;

   logic        in_ready, out_valid, out_crc_ok, locked;
   logic [12:0] out_data;
   logic [15:0] err_cnt, word_cnt;
   logic        in_ready4, out_valid4, out_crc_ok4, locked4;
   logic [12:0] out_data4;
   logic [3:0]  err_cnt4, word_cnt4;

   int n_checks = 0;
   int n_fail   = 0;

   bit          m_valid, m_ok, m_locked;
   logic [12:0] m_data;
   int          m_good, m_bad, m_words, m_errs;

   always #5 clk = ~clk;

   pflink_crc_checker dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_crc_ok(out_crc_ok),
      .locked(locked), .cnt_clr(cnt_clr), .err_cnt(err_cnt), .word_cnt(word_cnt)
   );

   pflink_crc_checker #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_crc_ok(out_crc_ok4),
      .locked(locked4), .cnt_clr(cnt_clr), .err_cnt(err_cnt4), .word_cnt(word_cnt4)
   );

   // Reference CRC: remainder of payload*x^8 divided by x^8+x^2+x+1 (long division).
   function automatic int ref_crc(int payload);
      int r;
      r = payload << 8;
      for (int b = 20; b >= 8; b--) begin
         if (r[b]) r = r ^ (32'h107 << (b - 8));
      end
      return r & 255;
   endfunction

   function automatic logic [20:0] mk_word(int payload, bit good);
      int c;
      c = ref_crc(payload);
      if (!good) c = c ^ int'($urandom_range(1, 255));
      return {13'(payload), 8'(c)};
   endfunction

   function automatic int sat(int c, int w);
      int mx;
      mx = (1 << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
      chk({tag, ".out_crc_ok"}, 32'(out_crc_ok), 32'(m_ok));
      chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
      chk({tag, ".err_cnt"}, 32'(err_cnt), STATS ? sat(m_errs, 16) : 0);
      chk({tag, ".word_cnt"}, 32'(word_cnt), STATS ? sat(m_words, 16) : 0);
      chk({tag, ".err_cnt4"}, 32'(err_cnt4), STATS ? sat(m_errs, 4) : 0);
      chk({tag, ".word_cnt4"}, 32'(word_cnt4), STATS ? sat(m_words, 4) : 0);
      chk({tag, ".dp4"}, {17'd0, out_valid4, out_crc_ok4, out_data4, locked4},
          {17'd0, m_valid, m_ok, m_data, m_locked});
   endtask

   // One clock cycle: apply inputs, check in_ready, advance the model, sample after the edge.
   task automatic drive(bit v, bit r, logic [20:0] d, bit clr);
      bit acc, ok;
      in_valid = v; out_ready = r; in_data = d; cnt_clr = clr;
      #1;
      chk("in_ready", 32'(in_ready), 32'(!m_valid || r));
      chk("in_ready4", 32'(in_ready4), 32'(!m_valid || r));
      acc = v && (!m_valid || r);
      ok  = (ref_crc(int'(d[20:8])) == int'(d[7:0]));
      if (acc) begin
         m_valid = 1'b1; m_data = d[20:8]; m_ok = ok;
         if (!m_locked) begin
            if (!ok) m_good = 0;
            else begin
               m_good++;
               if (m_good == LOCK_N) begin m_locked = 1'b1; m_good = 0; m_bad = 0; end
            end
         end else begin
            if (ok) m_bad = 0;
            else begin
               m_bad++;
               if (m_bad == UNLOCK_N) begin m_locked = 1'b0; m_good = 0; m_bad = 0; end
            end
         end
         if (!clr) begin
            m_words++;
            if (!ok) m_errs++;
         end
      end else if (r) begin
         m_valid = 1'b0;
      end
      if (clr) begin m_words = 0; m_errs = 0; end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; cnt_clr = 1'b0;
      rst_n = 1'b0;
      #1;
      m_valid = 0; m_data = '0; m_ok = 0; m_locked = 0;
      m_good = 0; m_bad = 0; m_words = 0; m_errs = 0;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      check_all("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          v;
      bit          r;
      bit          clr;
      logic [20:0] d;
      bit          e_valid;
      logic [12:0] e_data;
      bit          e_ok;
      int          e_words;
      int          e_errs;
   } vec_t;

   vec_t tbl[5];
   int   bad_pat[8] = '{0, 0, 0, 1, 0, 0, 0, 0};

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b0, 21'h000107, 1'b1, 13'h0001, 1'b1, 1, 0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 21'h000106, 1'b1, 13'h0001, 1'b0, 2, 1};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 21'h100057, 1'b1, 13'h1000, 1'b1, 3, 1};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 21'h000000, 1'b0, 13'h1000, 1'b1, 3, 1};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 21'h000106, 1'b1, 13'h0001, 1'b0, 0, 0};

      #12;
      do_reset();

      for (int i = 0; i < 5; i++) begin
         drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].clr);
         chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
         chk($sformatf("tbl%0d.out_data", i), 32'(out_data), 32'(tbl[i].e_data));
         chk($sformatf("tbl%0d.out_crc_ok", i), 32'(out_crc_ok), 32'(tbl[i].e_ok));
         chk($sformatf("tbl%0d.word_cnt", i), 32'(word_cnt), STATS ? tbl[i].e_words : 0);
         chk($sformatf("tbl%0d.err_cnt", i), 32'(err_cnt), STATS ? tbl[i].e_errs : 0);
      end

      // Lock acquisition and loss.
      do_reset();
      for (int i = 0; i < LOCK_N; i++) begin
         drive(1'b1, 1'b1, mk_word(int'($urandom_range(0, 8191)), 1'b1), 1'b0);
         check_all("lock");
         chk($sformatf("lock.acq%0d", i), 32'(locked), 32'(i == LOCK_N - 1));
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, mk_word(int'($urandom_range(0, 8191)), bad_pat[i] == 1), 1'b0);
         check_all("unlock");
         chk($sformatf("unlock.step%0d", i), 32'(locked), 32'(i != 7));
      end

      // Backpressure: first word held, second taken when out_ready returns.
      drive(1'b0, 1'b1, '0, 1'b1);
      drive(1'b1, 1'b0, 21'h000107, 1'b0);
      check_all("bp.a");
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 21'h100057, 1'b0);
         chk("bp.hold_ready", 32'(in_ready), 32'd0);
         chk("bp.hold_data", 32'(out_data), 32'h001);
         check_all("bp.hold");
      end
      drive(1'b1, 1'b1, 21'h100057, 1'b0);
      chk("bp.b_data", 32'(out_data), 32'h1000);
      check_all("bp.b");
      drive(1'b0, 1'b1, '0, 1'b0);
      chk("bp.drain", 32'(out_valid), 32'd0);
      chk("bp.word_cnt", 32'(word_cnt), STATS ? 2 : 0);

      // Saturation and clear priority.
      drive(1'b0, 1'b1, '0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, mk_word(int'($urandom_range(0, 8191)), 1'b0), 1'b0);
         check_all("sat");
      end
      chk("sat.err4", 32'(err_cnt4), STATS ? 15 : 0);
      chk("sat.err16", 32'(err_cnt), STATS ? 20 : 0);
      drive(1'b1, 1'b1, mk_word(5, 1'b0), 1'b1);
      chk("clr.err4", 32'(err_cnt4), 32'd0);
      chk("clr.err16", 32'(err_cnt), 32'd0);
      check_all("clr");

      // Async reset while locked with a word held.
      for (int i = 0; i < LOCK_N; i++) begin
         drive(1'b1, 1'b1, mk_word(int'($urandom_range(0, 8191)), 1'b1), 1'b0);
      end
      out_ready = 1'b0;
      chk("pre_rst.locked", 32'(locked), 32'd1);
      chk("pre_rst.out_valid", 32'(out_valid), 32'd1);
      do_reset();
      check_all("post_rst");

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               mk_word(int'($urandom_range(0, 8191)), 1'($urandom_range(0, 4) != 0)),
               1'($urandom_range(0, 19) == 0));
         check_all("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pflink_crc_checker.md
Name: pflink_crc_checker

Overview:
- Receive-side stage of the pflink path. Consumes 21-bit link words made of a 13-bit payload and an 8-bit CRC.
- Recomputes CRC-8 over the payload (x^8+x^2+x+1, init 0x00, first serial bit = payload[12]) and compares it with the received CRC.
- Forwards the payload with a per-word pass/fail flag through a one-deep valid/ready register.
- Maintains link lock state and error statistics for slow control.

Parameters:
- LOCK_CNT, 8, consecutive good words required in HUNT before asserting lock (1..255).
- UNLOCK_CNT, 4, consecutive bad words in LOCKED that drop lock (1..255).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  link clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage can accept a word.
- in_data  in  21  {payload[12:0], crc[7:0]}; payload = in_data[20:8].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  13  payload.
- out_crc_ok  out  1  1 = computed CRC equals received CRC.
- locked  out  1  lock FSM is in LOCKED.
- cnt_clr  in  1  synchronous clear of statistics counters.
- err_cnt  out  CNT_W  saturating count of bad words.
- word_cnt  out  CNT_W  saturating count of accepted words.

Behaviour:
- Reset (async assert, synchronous release): out_valid=0, out_data=0, out_crc_ok=0, locked=0, FSM=HUNT, good/bad run counters=0, err_cnt=0, word_cnt=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). A word is accepted when in_valid && in_ready.
  - On accept, out_data, out_crc_ok and out_valid=1 register on the next edge; latency is 1 cycle.
  - With out_valid=1 and out_ready=0, outputs hold stable and in_ready=0.
  - out_valid clears on out_ready when no new word is accepted.
  - Full throughput: a word can be accepted on every cycle while out_ready=1.
- CRC: combinational over in_data[20:8] at accept time; ok = (crc8(payload) == in_data[7:0]).
- Lock FSM. It updates only on accepted words, evaluated on that word's ok:
  - HUNT:
    - ok: good_run++. When good_run reaches LOCK_CNT, go to LOCKED and clear both runs.
    - bad: good_run=0.
  - LOCKED:
    - bad: bad_run++. When bad_run reaches UNLOCK_CNT, go to HUNT and clear both runs.
    - ok: bad_run=0.
  - locked is registered and equals (state==LOCKED). It changes on the same edge that registers the deciding word.
- Counters:
  - word_cnt increments on each accept; err_cnt increments on each accepted bad word.
  - Both saturate at all-ones and never wrap.
  - cnt_clr zeroes both on the next edge. Clear wins over a same-cycle increment, so that event is not counted.
  - cnt_clr does not affect the FSM or the datapath.
- Idle cycles (no accept) leave FSM, runs and counters unchanged.
- Reset mid-word discards any held output word; the FSM returns to HUNT.

Optional Feature:
- Macro PFLINK_CRC_STATS_EN.
- Defined: err_cnt/word_cnt as above.
- Undefined: counter registers are not built, err_cnt and word_cnt are tied to 0, and cnt_clr is ignored. Lock FSM and datapath are unchanged.

Decomposition:
- Package pflink_crc_pkg:
  - widths PAYLOAD_W=13, CRC_W=8, WORD_W=21.
  - polynomial constant 8'h07.
  - CRC init 8'h00.
  - FSM state encoding (HUNT=0, LOCKED=1).
- Sub-module pflink_crc8_calc13: purely combinational CRC-8 over 13 bits, instantiated once.
- FSM, counters and output register stay in pflink_crc_checker.

Test Plan:
- Good word: in_data=21'h000107 (payload 0x001, crc 0x07), out_ready=1 -> next cycle out_valid=1, out_data=0x001, out_crc_ok=1, word_cnt=1, err_cnt=0.
- Bad word: in_data=21'h000106 -> out_crc_ok=0, err_cnt=1. Also check payload 0x1000 with crc 0x57 gives ok=1 (in_data=21'h100057).
- Lock acquire/loss (defaults):
  - 8 consecutive good words -> locked rises on the edge registering the 8th.
  - Then 3 bad, 1 good, 4 bad -> locked falls only after the 4th bad of the final run.
- Backpressure: out_ready=0 with two words offered -> first held stable, in_ready=0, second accepted the cycle out_ready returns; no loss or duplication, word_cnt=2.
- Saturation/clear: CNT_W=4, 20 bad words -> err_cnt=15. cnt_clr coincident with a bad word -> err_cnt=0 next cycle.
- Async reset mid-stream: rst_n low while out_valid=1 and locked=1 -> out_valid=0 and locked=0 immediately. Without PFLINK_CRC_STATS_EN, counters read 0 throughout.
